pkt_framer: RTL
===============

# pkt_framer

Upstream packet source for the parallel-mux checker stage. Accepts raw payload words through a valid/ready handshake and buffers them in a 2-entry FIFO. Emits one framed bus word per cycle: all-ones header word, payload in the middle words, running sequence number in the least-significant word. Optional per-packet fault injection (bad header, skipped sequence) drives the downstream error paths.

## Interface
- BUS_SIZE, 16, framed bus width.
- WORD_SIZE, 4, width of header and sequence fields.
- WORD_NUM, BUS_SIZE/WORD_SIZE, derived; must be ≥ 3.
- PAY_SIZE, BUS_SIZE-2*WORD_SIZE, derived payload width (8 by default).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- payload_in  in  PAY_SIZE  raw payload.
- payload_valid  in  1  payload_in is valid this cycle.
- payload_ready  out  1  FIFO can accept; equals "FIFO not full".
- inject_hdr_err  in  1  corrupt the header of the packet popped this cycle.
- inject_seq_err  in  1  skip one sequence value for the packet popped this cycle.
- bus_data_out  out  BUS_SIZE  framed word: [BUS_SIZE-1 -: WORD_SIZE] header, middle PAY_SIZE bits payload, [WORD_SIZE-1:0] sequence.
- bus_valid  out  1  bus_data_out holds a new packet this cycle.
- state  out  2  current FSM state (debug).
- pkt_count  out  8  packets emitted since reset, wraps 255→0.

## Operation
- Reset applied with reset==0 at a rising edge. All outputs and state then read: bus_data_out=0, bus_valid=0, payload_ready=1, state=IDLE, pkt_count=0. FIFO is emptied and the next sequence value is 1.
- Push occurs when payload_valid && payload_ready. Pop occurs every cycle the FIFO is non-empty. Push and pop in the same cycle are legal at occupancy 1. At occupancy 2 no push occurs, because ready is 0. Occupancy never exceeds 2, and data is never lost or duplicated.
- The packet popped is registered to bus_data_out with bus_valid=1:
  - header = all ones, or all ones with bit 0 cleared if inject_hdr_err;
  - payload = FIFO head;
  - seq = next_seq, or next_seq advanced twice if inject_seq_err.
- When no pop occurs, bus_valid=0 and bus_data_out holds its last value.
- Sequence advance: value v goes to v+1, and 2^WORD_SIZE-1 wraps to 1. Zero is never emitted. With the skip, 14→1 and 15→2. The stored next_seq equals the emitted seq +1, following the same wrap rule.
- pkt_count increments on every emitted packet, injected ones included.
- FSM states:
  - IDLE (0): nothing emitted since reset. On pop → FIRST.
  - FIRST (1): the first packet (seq 1 unless skipped) is on the bus. Pop → STREAM; no pop → GAP.
  - STREAM (2): consecutive packets. Pop → STREAM; no pop → GAP.
  - GAP (3): bus idle mid-stream. Pop → STREAM; the sequence continues and does not restart at 1.
- Only reset returns the FSM to IDLE. Reset mid-stream discards FIFO contents and clears bus_valid in that same cycle.

## Timing
- Payload accepted at edge k is emitted at edge k+1 (bus_valid high in cycle k+1) if the FIFO was empty. Otherwise it is emitted one cycle later per entry ahead of it.
- payload_ready is registered and reflects occupancy after edge k. The FIFO never fills under continuous valid, so throughput is 1 packet/cycle.
- inject_* inputs are sampled only at edges where a pop occurs. At all other edges they are ignored.
- Outputs are fully registered; there are no combinational input→output paths.

## Test plan
- Reset mid-stream: hold reset=0 for 2 cycles while payload_valid=1 → bus_valid=0, payload_ready=1, state=0, pkt_count=0. The first post-reset packet carries seq 1.
- Single packet: payload 0xA5 accepted at edge k → cycle k+1 shows bus_data_out=0xFA51, bus_valid=1, state=1. Cycle k+2 shows bus_valid=0, state=3.
- Stream and wrap: 16 consecutive payloads 0x00..0x0F → sequences 1..15 then 1, one packet per cycle, payload_ready constantly 1, pkt_count=16.
- Header injection: inject_hdr_err=1 on the pop of payload 0x3C with seq 2 → bus_data_out=0xE3C2. The next packet has header 0xF and seq 3.
- Sequence skip at wrap: next_seq=14 and inject_seq_err=1 → emitted seq 1. The following packet has seq 2.
- Backpressure and gap: on payload_valid pulses with idle cycles between them → state alternates 2/3, the sequence stays contiguous, and no payload is dropped (compare against a scoreboard).

Source files
------------

// File: rtl/pkt_framer.sv
// pkt_framer: upstream packet source for the parallel-mux checker stage.
//
// Raw payload words enter through a valid/ready handshake into a 2-entry FIFO.
// Each cycle the FIFO is non-empty, its head is popped and registered onto the
// bus as one framed word: {header, payload, sequence}. The header is all ones
// and the sequence field counts 1..2^WORD_SIZE-1, skipping zero. Per-packet
// fault injection can corrupt the header or skip sequence values, which
// exercises the downstream error paths.
//
// Ports:
//   clk             clock, all logic on the rising edge
//   reset           synchronous, active-low
//   payload_in      raw payload word
//   payload_valid   payload_in is valid this cycle
//   payload_ready   FIFO not full (registered)
//   inject_hdr_err  clear header bit 0 on the packet popped this cycle
//   inject_seq_err  advance the sequence twice for the packet popped this cycle
//   bus_data_out    framed word, held while bus_valid is low
//   bus_valid       bus_data_out carries a new packet this cycle
//   state           FSM state (debug): 0 idle, 1 first, 2 stream, 3 gap
//   pkt_count       packets emitted since reset, wraps at 255
module pkt_framer #(
    parameter int unsigned BUS_SIZE  = 16,
    parameter int unsigned WORD_SIZE = 4,
    parameter int unsigned WORD_NUM  = BUS_SIZE / WORD_SIZE,
    parameter int unsigned PAY_SIZE  = BUS_SIZE - 2 * WORD_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PAY_SIZE-1:0] payload_in,
    input  logic                payload_valid,
    output logic                payload_ready,
    input  logic                inject_hdr_err,
    input  logic                inject_seq_err,
    output logic [BUS_SIZE-1:0] bus_data_out,
    output logic                bus_valid,
    output logic [1:0]          state,
    output logic [7:0]          pkt_count
);

    if (WORD_NUM < 3) begin : g_bad_word_num
        $error("pkt_framer: WORD_NUM must be at least 3");
    end

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFirst  = 2'd1,
        StStream = 2'd2,
        StGap    = 2'd3
    } state_e;

    localparam logic [WORD_SIZE-1:0] HdrOk  = '1;
    localparam logic [WORD_SIZE-1:0] HdrBad = {{(WORD_SIZE - 1){1'b1}}, 1'b0};

    // Sequence advance; the all-ones value wraps to 1 so zero is never used.
    function automatic logic [WORD_SIZE-1:0] seq_inc(input logic [WORD_SIZE-1:0] v);
        return (v == '1) ? WORD_SIZE'(1) : v + 1'b1;
    endfunction

    state_e              state_q;
    logic [PAY_SIZE-1:0] fifo_mem [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic [WORD_SIZE-1:0] next_seq_q;
    logic [WORD_SIZE-1:0] seq_emit;
    logic [WORD_SIZE-1:0] hdr_emit;
    logic                push;
    logic                pop;

    assign push     = payload_valid && payload_ready;
    assign pop      = (count_q != 2'd0);
    assign seq_emit = inject_seq_err ? seq_inc(seq_inc(next_seq_q)) : next_seq_q;
    assign hdr_emit = inject_hdr_err ? HdrBad : HdrOk;
    assign state    = state_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            payload_ready <= 1'b1;
            next_seq_q    <= WORD_SIZE'(1);
            bus_data_out  <= '0;
            bus_valid     <= 1'b0;
            pkt_count     <= 8'd0;
            state_q       <= StIdle;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= payload_in;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            count_q       <= count_d;
            payload_ready <= (count_d != 2'd2);
            bus_valid     <= pop;

            if (pop) begin
                rd_ptr_q     <= ~rd_ptr_q;
                bus_data_out <= {hdr_emit, fifo_mem[rd_ptr_q], seq_emit};
                next_seq_q   <= seq_inc(seq_emit);
                pkt_count    <= pkt_count + 8'd1;
            end

            unique case (state_q)
                StIdle:   state_q <= pop ? StFirst : StIdle;
                StFirst,
                StStream,
                StGap:    state_q <= pop ? StStream : StGap;
                default:  state_q <= StIdle;
            endcase
        end
    end

endmodule
